// File: rtl/wrapper_write_arbiter_if.sv
// Write-side bus between the requesters and wrapper_write_arbiter.
// The arbiter takes the slave modport; the requesters and the buffer take the master modport.
interface wrapper_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        grant;
    logic                    buffer_full;
    logic [DATA_W-1:0]       data_1;
    logic                    data_1_en;
    logic                    busy;

    modport master (
        output req, req_data, buffer_full,
        input  ack, grant, data_1, data_1_en, busy
    );

    modport slave (
        input  req, req_data, buffer_full,
        output ack, grant, data_1, data_1_en, busy
    );
endinterface

// File: rtl/wrapper_write_arbiter.sv
// Round-robin arbiter sharing the buffer write port (data_1/data_1_en) among N_REQ requesters.
// Define WRARB_BURST_EN for grants of up to MAX_BURST words; by default each grant carries one word.
module wrapper_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk_1,
    input  logic                   reset,
    wrapper_write_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            r_state;
    logic [N_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_last_owner;
    logic              r_busy;

    logic [N_REQ-1:0]  w_ack;
    logic              w_ack_any;
    logic              w_owner_req;
    logic              w_last_beat;
    logic              w_release;
    logic              w_win_found;
    logic [IDX_W-1:0]  w_win_idx;
    logic [IDX_W-1:0]  w_scan;
    logic [DATA_W-1:0] w_data;

`ifdef WRARB_BURST_EN
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [CNT_W-1:0]  r_burst_cnt;
    assign w_last_beat = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
`else
    assign w_last_beat = 1'b1;
`endif

    // Gating with buffer_full here keeps a write from ever reaching a full buffer on the same edge.
    assign w_ack       = r_grant & bus.req & {N_REQ{~bus.buffer_full}};
    assign w_ack_any   = |w_ack;
    assign w_owner_req = |(r_grant & bus.req);
    assign w_release   = (r_state == S_GRANT) && (!w_owner_req || (w_ack_any && w_last_beat));

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan = IDX_W'((int'(r_last_owner) + k) % N_REQ);
            if (!w_win_found && bus.req[w_scan]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_ack[i]) begin
                w_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: reset is asynchronous, so dropping it mid-burst clears grant (and thus ack) at once.
    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDX_W'(N_REQ - 1);
            r_busy       <= 1'b0;
`ifdef WRARB_BURST_EN
            r_burst_cnt  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_state     <= S_GRANT;
                        r_grant     <= N_REQ'(1) << w_win_idx;
                        r_owner     <= w_win_idx;
                        r_busy      <= 1'b1;
`ifdef WRARB_BURST_EN
                        r_burst_cnt <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state      <= S_IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                    end
`ifdef WRARB_BURST_EN
                    else if (w_ack_any) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = w_ack;
    assign bus.grant     = r_grant;
    assign bus.data_1    = w_data;
    assign bus.data_1_en = w_ack_any;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_wrapper_write_arbiter.sv
// Scoreboard bench for wrapper_write_arbiter; expectations follow WRARB_BURST_EN when it is defined.
module tb_wrapper_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic clk_1 = 1'b0;
    logic reset;

    always #5 clk_1 = ~clk_1;

    wrapper_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    wrapper_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk_1 (clk_1),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          who;
        logic [DW-1:0] word;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] src_mem [N][32];
    int            src_rd [N];
    int            src_wr [N];
    int            n_vec = 0;
    int            n_err = 0;

    logic [N-1:0]  s_ack, s_grant, s_req;
    logic          s_busy, s_en, s_full;
    logic [DW-1:0] s_data;

    logic [N-1:0]  g_eg[$];
    logic          g_full[$];

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
    endtask

    task automatic offer(input int who, input logic [DW-1:0] w);
        src_mem[who][src_wr[who]] = w;
        src_wr[who]++;
    endtask

    task automatic expect_w(input int who, input logic [DW-1:0] w);
        exp_t e;
        e.who  = who;
        e.word = w;
        sb.push_back(e);
    endtask

    task automatic push_pat(input logic [N-1:0] g, input int times);
        for (int k = 0; k < times; k++) g_eg.push_back(g);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_rd[i] < src_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                bus.req[i]                = 1'b1;
                bus.req_data[i*DW +: DW]  = src_mem[i][src_rd[i]];
            end else begin
                bus.req[i]                = 1'b0;
                bus.req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // One clock: sample at the falling edge, score any write, then advance requesters after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk_1);
        s_ack   = bus.ack;
        s_grant = bus.grant;
        s_busy  = bus.busy;
        s_en    = bus.data_1_en;
        s_data  = bus.data_1;
        s_req   = bus.req;
        s_full  = bus.buffer_full;
        n_vec++;
        if (s_en !== ((|(s_grant & s_req)) & ~s_full)) begin
            n_err++;
            $display("FAIL en_rule: data_1_en=%b required %b (grant=%b req=%b full=%b)",
                     s_en, (|(s_grant & s_req)) & ~s_full, s_grant, s_req, s_full);
        end
        n_vec++;
        if (s_en) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: write of %h with ack=%b, required no write", s_data, s_ack);
            end else begin
                e = sb.pop_front();
                if (s_ack !== (4'b0001 << e.who) || s_data !== e.word) begin
                    n_err++;
                    $display("FAIL sb_word: ack=%b data_1=%h, required ack=%b data_1=%h",
                             s_ack, s_data, 4'b0001 << e.who, e.word);
                end
            end
        end else if (s_ack !== '0 || s_data !== '0) begin
            n_err++;
            $display("FAIL idle_bus: ack=%b data_1=%h, required 0000 and 0000", s_ack, s_data);
        end
        @(posedge clk_1);
        #1;
        for (int i = 0; i < N; i++) if (s_ack[i]) src_rd[i]++;
        drive_inputs();
    endtask

    task automatic run_pattern(input string name);
        for (int c = 0; c < g_eg.size(); c++) begin
            bus.buffer_full = (c < g_full.size()) ? g_full[c] : 1'b0;
            step();
            n_vec++;
            if (s_grant !== g_eg[c]) begin
                n_err++;
                $display("FAIL %s cycle %0d: grant=%b required %b", name, c, s_grant, g_eg[c]);
            end
        end
        bus.buffer_full = 1'b0;
        g_eg.delete();
        g_full.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && all_empty() && !s_busy && s_grant == '0) && n < budget);
        n_vec++;
        if (sb.size() != 0 || !all_empty() || s_busy) begin
            n_err++;
            $display("FAIL %s: after %0d cycles %0d words unwritten, busy=%b, required 0 and 0",
                     name, n, sb.size(), s_busy);
        end
    endtask

    task automatic test_reset();
        clear_src();
        for (int i = 0; i < N; i++) begin
            offer(i, 16'hA000 + 16'(i));
            expect_w(i, 16'hA000 + 16'(i));
        end
        bus.buffer_full = 1'b0;
        drive_inputs();
        step();
        step();
        n_vec++;
        if (s_grant !== '0) begin n_err++; $display("FAIL reset_grant: grant=%b required 0000", s_grant); end
        n_vec++;
        if (s_ack !== '0) begin n_err++; $display("FAIL reset_ack: ack=%b required 0000", s_ack); end
        n_vec++;
        if (s_en !== 1'b0) begin n_err++; $display("FAIL reset_en: data_1_en=%b required 0", s_en); end
        n_vec++;
        if (s_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: busy=%b required 0", s_busy); end
        reset = 1'b1;
        push_pat('0, 1);
        for (int i = 0; i < N; i++) begin
`ifdef WRARB_BURST_EN
            push_pat(4'b0001 << i, 2);
`else
            push_pat(4'b0001 << i, 1);
`endif
            push_pat('0, 1);
        end
        run_pattern("reset_first_grant");
        drain("reset_drain", 40);
    endtask

    task automatic test_round_robin();
        int order[3] = '{0, 1, 3};
        clear_src();
        for (int j = 0; j < 3; j++)
            for (int rep = 0; rep < 2; rep++)
                offer(order[j], 16'hB000 + 16'(rep*16 + order[j]));
        drive_inputs();
        push_pat('0, 1);
`ifdef WRARB_BURST_EN
        for (int j = 0; j < 3; j++) begin
            push_pat(4'b0001 << order[j], 3);
            push_pat('0, 1);
            for (int rep = 0; rep < 2; rep++) expect_w(order[j], 16'hB000 + 16'(rep*16 + order[j]));
        end
`else
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 3; j++) begin
                push_pat(4'b0001 << order[j], 1);
                push_pat('0, 1);
                expect_w(order[j], 16'hB000 + 16'(rep*16 + order[j]));
            end
        end
`endif
        run_pattern("rr_grant");
        drain("rr_drain", 40);
    endtask

    task automatic test_burst_limit();
        clear_src();
        for (int k = 0; k < 12; k++) begin
            offer(2, 16'h0100 + 16'(k));
            expect_w(2, 16'h0100 + 16'(k));
        end
        drive_inputs();
        push_pat('0, 1);
`ifdef WRARB_BURST_EN
        push_pat(4'b0100, MB);
        push_pat('0, 1);
        push_pat(4'b0100, 12 - MB + 1);
        push_pat('0, 1);
`else
        for (int k = 0; k < 12; k++) begin
            push_pat(4'b0100, 1);
            push_pat('0, 1);
        end
`endif
        run_pattern("burst_grant");
        drain("burst_drain", 40);
    endtask

    task automatic test_full_stall();
        clear_src();
        for (int k = 0; k < 6; k++) begin
            offer(0, 16'hC000 + 16'(k));
            expect_w(0, 16'hC000 + 16'(k));
        end
        drive_inputs();
        g_full.push_back(1'b0);
        g_full.push_back(1'b0);
        for (int k = 0; k < 3; k++) g_full.push_back(1'b1);
        push_pat('0, 1);
`ifdef WRARB_BURST_EN
        push_pat(4'b0001, 10);
        push_pat('0, 1);
`else
        push_pat(4'b0001, 1);
        push_pat('0, 1);
        push_pat(4'b0001, 3);
        for (int k = 0; k < 4; k++) begin
            push_pat('0, 1);
            push_pat(4'b0001, 1);
        end
        push_pat('0, 1);
`endif
        run_pattern("stall_grant");
        drain("stall_drain", 40);
    endtask

    task automatic test_early_release();
        clear_src();
        for (int k = 0; k < 3; k++) offer(1, 16'hD001 + 16'(k*16));
        for (int k = 0; k < 2; k++) offer(3, 16'hD003 + 16'(k*16));
        drive_inputs();
        push_pat('0, 1);
`ifdef WRARB_BURST_EN
        push_pat(4'b0010, 4);
        push_pat('0, 1);
        push_pat(4'b1000, 3);
        push_pat('0, 1);
        for (int k = 0; k < 3; k++) expect_w(1, 16'hD001 + 16'(k*16));
        for (int k = 0; k < 2; k++) expect_w(3, 16'hD003 + 16'(k*16));
`else
        for (int k = 0; k < 3; k++) begin
            push_pat(4'b0010, 1);
            push_pat('0, 1);
            expect_w(1, 16'hD001 + 16'(k*16));
            if (k < 2) begin
                push_pat(4'b1000, 1);
                push_pat('0, 1);
                expect_w(3, 16'hD003 + 16'(k*16));
            end
        end
`endif
        run_pattern("early_grant");
        drain("early_drain", 40);
    endtask

    task automatic test_async_reset();
        clear_src();
        for (int k = 0; k < 8; k++) offer(0, 16'hE000 + 16'(k));
        for (int k = 0; k < 4; k++) expect_w(0, 16'hE000 + 16'(k));
        drive_inputs();
        push_pat('0, 1);
        for (int k = 0; k < 4; k++) begin
            push_pat(4'b0001, 1);
`ifndef WRARB_BURST_EN
            if (k < 3) push_pat('0, 1);
`endif
        end
        run_pattern("areset_pre");
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.grant !== '0 || bus.data_1_en !== 1'b0) begin
            n_err++;
            $display("FAIL areset_immediate: grant=%b data_1_en=%b, required 0000 and 0",
                     bus.grant, bus.data_1_en);
        end
        offer(3, 16'hE303);
        drive_inputs();
        step();
        n_vec++;
        if (s_grant !== '0 || s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL areset_held: grant=%b busy=%b, required 0000 and 0", s_grant, s_busy);
        end
        reset = 1'b1;
`ifdef WRARB_BURST_EN
        for (int k = 4; k < 8; k++) expect_w(0, 16'hE000 + 16'(k));
        expect_w(3, 16'hE303);
`else
        expect_w(0, 16'hE004);
        expect_w(3, 16'hE303);
        for (int k = 5; k < 8; k++) expect_w(0, 16'hE000 + 16'(k));
`endif
        push_pat('0, 1);
        push_pat(4'b0001, 1);
        run_pattern("areset_regrant");
        drain("areset_drain", 60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.req         = '0;
        bus.req_data    = '0;
        bus.buffer_full = 1'b0;
        #2;
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_full_stall();
        test_early_release();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
